octal_display_mux: RTL

Four-digit multiplexed seven-segment driver that shows a 12-bit PDP-8 word (PC, AC or switch register) as four octal digits on the board display. It sits downstream of the CPU top level, consumes a word plus four decimal-point flags, and drives the `sevenseg`/`sevenseg_an` pins. Updates are double-buffered: new words are captured on a load strobe and applied only at a scan-frame boundary, so a digit never changes partway through a frame.

---
 rtl/octal_display_mux.sv | 137 +++++++++++++
 1 files changed

// File: rtl/octal_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : octal_display_mux
// Brief    : Four-digit multiplexed seven-segment driver showing a 12-bit word
//            as octal digits, with frame-aligned double-buffered updates.
// Revision : 1.0 - initial release
// ============================================================================
module octal_display_mux #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] value,
    input  logic [3:0]  dots,
    input  logic        load,
    input  logic        blank,
    output logic [7:0]  sevenseg,
    output logic [3:0]  sevenseg_an,
    output logic        pending,
    output logic        frame
);

    localparam logic [15:0] c_last_count = 16'(PRESCALE - 1);
    localparam logic [1:0]  c_last_index = 2'd3;

    logic [15:0] r_count;
    logic [1:0]  r_index;
    logic [11:0] r_buf_value;
    logic [3:0]  r_buf_dots;
    logic [11:0] r_shadow_value;
    logic [3:0]  r_shadow_dots;
    logic        r_pending;
    logic        r_frame;
    logic [7:0]  r_seg;
    logic [3:0]  r_an;

    logic        w_tick;
    logic        w_boundary;
    logic [2:0]  w_digit;
    logic        w_dp;
    logic [7:0]  w_pattern;
    logic [7:0]  w_seg_next;
    logic [3:0]  w_an_next;

    assign w_tick     = (r_count == c_last_count);
    assign w_boundary = w_tick && (r_index == c_last_index);

    // Prescaler and digit scan run regardless of blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
            r_index <= 2'd0;
        end else if (w_tick) begin
            r_count <= 16'd0;
            r_index <= r_index + 2'd1;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    // A load coinciding with the boundary bypasses the pending buffer so the
    // newest word reaches the shadow without waiting a whole extra frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_value    <= 12'd0;
            r_buf_dots     <= 4'd0;
            r_shadow_value <= 12'd0;
            r_shadow_dots  <= 4'd0;
            r_pending      <= 1'b0;
            r_frame        <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (load) begin
                r_buf_value <= value;
                r_buf_dots  <= dots;
            end
            if (w_boundary) begin
                if (load) begin
                    r_shadow_value <= value;
                    r_shadow_dots  <= dots;
                end else if (r_pending) begin
                    r_shadow_value <= r_buf_value;
                    r_shadow_dots  <= r_buf_dots;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = r_shadow_value[2:0];
        w_dp    = r_shadow_dots[0];
        case (r_index)
            2'd0: begin w_digit = r_shadow_value[2:0];   w_dp = r_shadow_dots[0]; end
            2'd1: begin w_digit = r_shadow_value[5:3];   w_dp = r_shadow_dots[1]; end
            2'd2: begin w_digit = r_shadow_value[8:6];   w_dp = r_shadow_dots[2]; end
            default: begin w_digit = r_shadow_value[11:9]; w_dp = r_shadow_dots[3]; end
        endcase
    end

    always_comb begin
        w_pattern = 8'hFF;
        case (w_digit)
            3'd0: w_pattern = 8'hC0;
            3'd1: w_pattern = 8'hF9;
            3'd2: w_pattern = 8'hA4;
            3'd3: w_pattern = 8'hB0;
            3'd4: w_pattern = 8'h99;
            3'd5: w_pattern = 8'h92;
            3'd6: w_pattern = 8'h82;
            default: w_pattern = 8'hF8;
        endcase
    end

    assign w_seg_next = w_dp ? (w_pattern & 8'h7F) : w_pattern;
    assign w_an_next  = blank ? 4'b1111 : ~(4'b0001 << r_index);

    // Anode and segments share one register stage so they always switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= 8'hFF;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign sevenseg    = r_seg;
    assign sevenseg_an = r_an;
    assign pending     = r_pending;
    assign frame       = r_frame;

endmodule
`default_nettype wire
